// File: rtl/cnn_conv_1x1_weight_streamer.sv
// Weight streamer for a 1x1 convolution block.
// Captures one layer of weights through a sequential load port into a block RAM,
// then replays the whole set as a gap-free valid/data stream on every start pulse.
// The stored set survives a replay, so it can be streamed repeatedly until cleared.
module cnn_conv_1x1_weight_streamer #(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 7,
    parameter int ADDR_WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  loaded,
    output logic                  busy,
    output logic                  done
);

    localparam int                    WEIGHT_NUM = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WEIGHT_NUM - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_LOADED,
        S_STREAM
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH-1:0]   w_rd_ptr_nxt;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_rd_last;

    logic [DATA_WIDTH-1:0]   r_mem [WEIGHT_NUM];
    logic [DATA_WIDTH-1:0]   r_ram_q;
    logic                    r_rd_vld;
    logic                    r_rd_last;
    logic [DATA_WIDTH-1:0]   r_weight_out;
    logic                    r_valid;
    logic                    r_done;

    // State and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Next-state, pointer update and RAM port strobes; clear overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        if (clear) begin
            w_state_nxt  = S_EMPTY;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            unique case (r_state)
                // EMPTY always holds wr_ptr at 0, so it shares the LOADING path;
                // this also covers a single-word layer going straight to LOADED.
                S_EMPTY, S_LOADING: begin
                    if (wr_en) begin
                        w_wr = 1'b1;
                        if (r_wr_ptr == LAST_ADDR) begin
                            w_wr_ptr_nxt = '0;
                            w_state_nxt  = S_LOADED;
                        end else begin
                            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                            w_state_nxt  = S_LOADING;
                        end
                    end
                end
                S_LOADED: begin
                    if (start) begin
                        w_rd_ptr_nxt = '0;
                        w_state_nxt  = S_STREAM;
                    end
                end
                S_STREAM: begin
                    w_rd = 1'b1;
                    if (r_rd_ptr == LAST_ADDR) begin
                        w_rd_ptr_nxt = '0;
                        w_state_nxt  = S_LOADED;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    assign w_rd_last = w_rd && (r_rd_ptr == LAST_ADDR);

    // Synchronous block RAM: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
        if (w_rd) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    // Two-stage output pipeline (RAM latency + output register); clear flushes both stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_vld     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_weight_out <= '0;
        end else if (clear) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_vld  <= w_rd;
            r_rd_last <= w_rd_last;
            r_valid   <= r_rd_vld;
            r_done    <= r_rd_last;
            if (r_rd_vld) begin
                r_weight_out <= r_ram_q;
            end
        end
    end

    assign weight_out       = r_weight_out;
    assign valid_weight_out = r_valid;
    assign done             = r_done;
    assign busy             = (r_state == S_STREAM);
    assign loaded           = (r_state == S_LOADED) || (r_state == S_STREAM);

endmodule

// File: tb/tb_cnn_conv_1x1_weight_streamer.sv
// Scoreboard bench for cnn_conv_1x1_weight_streamer with a 4x2 (8-word) layer.
module tb_cnn_conv_1x1_weight_streamer;

    localparam int DW = 32;
    localparam int N  = 8;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          clear;
    logic [DW-1:0] weight_out;
    logic          valid_weight_out;
    logic          loaded;
    logic          busy;
    logic          done;

    cnn_conv_1x1_weight_streamer #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM_IN  (4),
        .CHANNEL_NUM_OUT (2),
        .ADDR_WIDTH      (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .start            (start),
        .clear            (clear),
        .weight_out       (weight_out),
        .valid_weight_out (valid_weight_out),
        .loaded           (loaded),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [32:0] sb[$];
    int          q_vcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (valid_weight_out) begin
            q_vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(weight_out), 32'hFFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("stream_data", weight_out, e[31:0]);
                check("stream_done", 32'(done), 32'(e[32]));
            end
        end else if (done) begin
            check("done_without_valid", 32'(done), 32'd0);
        end
    end

    task automatic load(input logic [31:0] base, input bit gaps, input int start_at);
        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 32'(i);
            start   = (i == start_at);
            @(negedge clk);
            start = 1'b0;
            check("loaded_during_load", 32'(loaded), 32'(i == N - 1));
            check("busy_during_load", 32'(busy), 32'd0);
            check("valid_during_load", 32'(valid_weight_out), 32'd0);
            if (gaps && i < N - 1) begin
                wr_en   = 1'b0;
                wr_data = 32'hDEAD_BEEF;
                @(negedge clk);
            end
        end
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic run_stream(input logic [31:0] base, input bit mid_start);
        int c0;
        for (int i = 0; i < N; i++) sb.push_back({(i == N - 1), base + 32'(i)});
        q_vcyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int k = 1; k <= N + 3; k++) begin
            start = mid_start && (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check("valid_count", 32'(q_vcyc.size()), 32'(N));
        for (int i = 0; i < q_vcyc.size(); i++) check("valid_cycle", 32'(q_vcyc[i]), 32'(c0 + 2 + i));
        check("busy_after_stream", 32'(busy), 32'd0);
        check("loaded_after_stream", 32'(loaded), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        start   = 1'b0;
        clear   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_weight_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_weight_out", weight_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // start in EMPTY is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_empty_busy", 32'(busy), 32'd0);

        // Continuous load with a start pulse during LOADING
        load(32'h10, 1'b0, 3);
        repeat (3) @(negedge clk);
        check("no_stream_after_load", 32'(q_vcyc.size()), 32'd0);

        // Write in LOADED must not overwrite
        wr_en   = 1'b1;
        wr_data = 32'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("loaded_after_extra_wr", 32'(loaded), 32'd1);

        // Stream with a start pulse mid-stream
        run_stream(32'h10, 1'b1);
        repeat (4) @(negedge clk);
        check("no_second_stream", 32'(q_vcyc.size()), 32'(N));

        // Back-to-back: second start in the cycle after busy falls
        for (int i = 0; i < 2 * N; i++) sb.push_back({((i % N) == N - 1), 32'h10 + 32'(i % N)});
        q_vcyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        check("busy_fell", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("b2b_valid_count", 32'(q_vcyc.size()), 32'(2 * N));
        if (q_vcyc.size() == 2 * N) begin
            check("b2b_first_contig", 32'(q_vcyc[N - 1] - q_vcyc[0]), 32'(N - 1));
            check("b2b_second_contig", 32'(q_vcyc[2 * N - 1] - q_vcyc[N]), 32'(N - 1));
            check("b2b_gap", 32'(q_vcyc[N] - q_vcyc[N - 1]), 32'd3);
        end

        // clear on the 4th valid cycle
        for (int i = 0; i < 4; i++) sb.push_back({1'b0, 32'h10 + 32'(i)});
        q_vcyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        repeat (5) @(negedge clk);
        clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'hBAD;
        @(negedge clk);
        clear = 1'b0;
        wr_en = 1'b0;
        check("clear_valid", 32'(valid_weight_out), 32'd0);
        check("clear_loaded", 32'(loaded), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("clear_word_count", 32'(q_vcyc.size()), 32'd4);
        check("clear_first_cycle", 32'(q_vcyc.size() > 0 ? q_vcyc[0] : 0), 32'(c0 + 2));

        // Gapped reload of a new set, then replay
        load(32'h20, 1'b1, -1);
        run_stream(32'h20, 1'b0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) sb.push_back({1'b0, 32'h20 + 32'(i)});
        q_vcyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_valid", 32'(valid_weight_out), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_loaded", 32'(loaded), 32'd0);
        check("areset_weight_out", weight_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("areset_word_count", 32'(q_vcyc.size()), 32'd3);

        // start ignored until a full reload
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_after_reset_busy", 32'(busy), 32'd0);
        check("start_after_reset_loaded", 32'(loaded), 32'd0);
        load(32'h30, 1'b0, -1);
        run_stream(32'h30, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
